// File: rtl/modular_square_ggg_sequencer_pkg.sv
// Shared types and helpers for the GGG squaring sequencer: FSM state encoding,
// phase-counter width derivation and the default redundant coefficient type.
package modular_square_ggg_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSquare,
        StDone
    } ggg_state_e;

    localparam int unsigned GggDefBitLen      = 51;
    localparam int unsigned GggDefPhaseCycles = 4;

    typedef logic [GggDefBitLen-1:0] ggg_coef_t;

    // A one-cycle phase still needs a 1-bit counter to keep the port legal.
    function automatic int unsigned ggg_phase_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned GggPhaseW = ggg_phase_w(GggDefPhaseCycles);

endpackage

// File: rtl/ggg_phase_counter.sv
// Per-iteration phase counter; decodes the mid-die capture strobe (second to
// last phase) and the iteration-complete phase.
module ggg_phase_counter
    import modular_square_ggg_sequencer_pkg::*;
#(
    parameter int unsigned Cycles = GggDefPhaseCycles,
    parameter int unsigned Width  = ggg_phase_w(Cycles)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic strobe,
    output logic last
);

    localparam logic [Width-1:0] LastPhase = Width'(Cycles - 1);

    logic [Width-1:0] phase_q, phase_d;

    assign last = (phase_q == LastPhase);

    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (run) begin
            phase_d = last ? '0 : phase_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    generate
        if (Cycles > 1) begin : g_strobe
            assign strobe = run && (phase_q == Width'(Cycles - 2));
        end else begin : g_no_strobe
            assign strobe = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/modular_square_ggg_sequencer.sv
// Sequences repeated modular squarings through an external datapath.
// Define GGG_MID_BYPASS_EN to route around the mid-die register (one fewer phase).
module modular_square_ggg_sequencer
    import modular_square_ggg_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = 21,
    parameter int unsigned BIT_LEN      = 51,
    parameter int unsigned ITER_WIDTH   = 40,
    parameter int unsigned PHASE_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [ITER_WIDTH-1:0]                  iterations,
    input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   sq_in,
    input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   sq_next,
    output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   sq_mid,
    output logic                                   phase_en,
    output logic                                   bypass,
    output logic                                   busy,
    output logic                                   valid,
    output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   sq_out,
    output logic [ITER_WIDTH-1:0]                  iter_count
);

`ifdef GGG_MID_BYPASS_EN
    localparam int unsigned EffCycles = PHASE_CYCLES - 1;
    localparam logic        BypassVal = 1'b1;
`else
    localparam int unsigned EffCycles = PHASE_CYCLES;
    localparam logic        BypassVal = 1'b0;
`endif

    localparam int unsigned PhaseW = ggg_phase_w(PHASE_CYCLES);

    typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] operand_t;

    ggg_state_e           state_q, state_d;
    operand_t             sq_mid_q, sq_mid_d;
    operand_t             sq_out_q, sq_out_d;
    logic [ITER_WIDTH-1:0] iter_count_q, iter_count_d;
    logic [ITER_WIDTH-1:0] iters_q, iters_d;

    logic ph_clear;
    logic ph_run;
    logic ph_strobe;
    logic ph_last;

    assign ph_run = (state_q == StSquare);

    ggg_phase_counter #(
        .Cycles (EffCycles),
        .Width  (PhaseW)
    ) u_phase_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (ph_clear),
        .run    (ph_run),
        .strobe (ph_strobe),
        .last   (ph_last)
    );

    always_comb begin
        state_d      = state_q;
        sq_mid_d     = sq_mid_q;
        sq_out_d     = sq_out_q;
        iter_count_d = iter_count_q;
        iters_d      = iters_q;
        ph_clear     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    iter_count_d = '0;
                    iters_d      = iterations;
                    ph_clear     = 1'b1;
                    if (iterations != '0) begin
                        sq_mid_d = sq_in;
                        state_d  = StSquare;
                    end else begin
                        sq_out_d = sq_in;
                        state_d  = StDone;
                    end
                end
            end
            StSquare: begin
                // Abort wins over the end-of-iteration writeback.
                if (abort) begin
                    ph_clear = 1'b1;
                    state_d  = StIdle;
                end else if (ph_last) begin
                    sq_mid_d     = sq_next;
                    iter_count_d = iter_count_q + ITER_WIDTH'(1);
                    if (iter_count_d == iters_q) begin
                        sq_out_d = sq_next;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            sq_mid_q     <= '0;
            sq_out_q     <= '0;
            iter_count_q <= '0;
            iters_q      <= '0;
        end else begin
            state_q      <= state_d;
            sq_mid_q     <= sq_mid_d;
            sq_out_q     <= sq_out_d;
            iter_count_q <= iter_count_d;
            iters_q      <= iters_d;
        end
    end

    assign sq_mid     = sq_mid_q;
    assign sq_out     = sq_out_q;
    assign iter_count = iter_count_q;
    assign phase_en   = ph_strobe;
    assign bypass     = BypassVal;
    assign busy       = (state_q != StIdle);
    assign valid      = (state_q == StDone) && !abort;

endmodule

// File: tb/tb_modular_square_ggg_sequencer.sv
// Scoreboard bench for the GGG squaring sequencer with a +1-per-squaring datapath model.
module tb_modular_square_ggg_sequencer;

    localparam int NE = 4;
    localparam int BL = 16;
    localparam int IW = 40;
    localparam int PC = 4;
`ifdef GGG_MID_BYPASS_EN
    localparam int   P         = PC - 1;
    localparam logic ExpBypass = 1'b1;
`else
    localparam int   P         = PC;
    localparam logic ExpBypass = 1'b0;
`endif

    typedef logic [NE-1:0][BL-1:0] op_t;
    typedef struct {
        op_t sq;
        int  iters;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [IW-1:0] iterations;
    op_t           sq_in, sq_next, sq_mid, sq_out;
    logic          phase_en, bypass, busy, valid;
    logic [IW-1:0] iter_count;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   pe_cnt = 0;
    int   pe_base = 0;
    exp_t sb[$];
    exp_t mon_e;
    op_t  last_out = '0;

    modular_square_ggg_sequencer #(
        .NUM_ELEMENTS (NE),
        .BIT_LEN      (BL),
        .ITER_WIDTH   (IW),
        .PHASE_CYCLES (PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .iterations (iterations),
        .sq_in      (sq_in),
        .sq_next    (sq_next),
        .sq_mid     (sq_mid),
        .phase_en   (phase_en),
        .bypass     (bypass),
        .busy       (busy),
        .valid      (valid),
        .sq_out     (sq_out),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: each squaring adds one to every coefficient.
    always_comb begin
        sq_next = sq_mid;
        for (int i = 0; i < NE; i++) sq_next[i] = sq_mid[i] + BL'(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (phase_en) pe_cnt++;
        if (busy && !valid) begin
            check_eq("phase_en_timing", phase_en,
                     ((cyc - start_cyc) % P) == (P - 2));
        end
        if (valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                for (int i = 0; i < NE; i++) check_eq("sq_out", sq_out[i], mon_e.sq[i]);
                check_eq("iter_count", iter_count, mon_e.iters);
                check_eq("latency", cyc - start_cyc + 1, mon_e.iters * P + 1);
                check_eq("phase_en_count", pe_cnt - pe_base, (P > 1) ? mon_e.iters : 0);
                check_eq("busy_in_done", busy, 1);
            end
        end
    end

    task automatic do_start(input int n, input op_t v, input bit expect_result);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        iterations = IW'(n);
        sq_in      = v;
        if (expect_result) begin
            for (int i = 0; i < NE; i++) e.sq[i] = v[i] + BL'(n);
            e.iters = n;
            sb.push_back(e);
            last_out = e.sq;
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        pe_base   = pe_cnt;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, n < 200, 1);
        check_eq({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_phase_en"}, phase_en, 0);
        check_eq({tag, "_iter_count"}, iter_count, 0);
        for (int i = 0; i < NE; i++) begin
            check_eq({tag, "_sq_out"}, sq_out[i], 0);
            check_eq({tag, "_sq_mid"}, sq_mid[i], 0);
        end
    endtask

    initial begin
        op_t v;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        iterations = '0;
        sq_in      = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        check_eq("bypass", bypass, ExpBypass);
        reset = 1'b0;

        // Nominal three-squaring run, coef0 starts at 5.
        for (int i = 0; i < NE; i++) v[i] = BL'(16 * i);
        v[0] = BL'(5);
        do_start(3, v, 1'b1);
        wait_idle("run3");

        // Zero iterations: immediate result, no strobes.
        for (int i = 0; i < NE; i++) v[i] = BL'(16'h1234 + i);
        do_start(0, v, 1'b1);
        wait_idle("run0");

        // Abort during cycle 6.
        for (int i = 0; i < NE; i++) v[i] = BL'(16'h0a00 + i);
        do_start(3, v, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_valid", valid, 0);
        for (int i = 0; i < NE; i++) check_eq("abort_sq_out", sq_out[i], last_out[i]);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_idle", busy, 0);

        // Start pulses while busy must be ignored.
        for (int i = 0; i < NE; i++) v[i] = BL'(16'h0100 * (i + 1));
        do_start(3, v, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; iterations = IW'(1); sq_in = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");

        // Asynchronous reset mid-squaring.
        for (int i = 0; i < NE; i++) v[i] = BL'(16'h7700 + i);
        do_start(3, v, 1'b0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        reset    = 1'b0;
        last_out = '0;
        for (int i = 0; i < NE; i++) v[i] = BL'(16'h0042 + i);
        do_start(2, v, 1'b1);
        wait_idle("post_reset");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NE; i++) v[i] = BL'($urandom);
            do_start(int'($urandom_range(1, 5)), v, 1'b1);
            wait_idle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
